barrel_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter/rotator. It supports logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit word, with valid/ready handshakes on both sides and a configurable number of register stages. It is the next-generation datapath shifter for the ALU and bit-manipulation paths, replacing the fixed 32-bit combinational rotator.

---
 rtl/barrel_shift_pkg.sv | 38 +++
 rtl/bsp_slice.sv | 117 +++++++++++
 rtl/barrel_shift_pipe.sv | 117 +++++++++++
 tb/tb_barrel_shift_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pkg.sv
// ---------------------------------------------------------------------------
// barrel_shift_pkg
//   Shared definitions for the pipelined barrel shifter (barrel_shift_pipe):
//   - bsp_op_e        : operation encoding (SLL, SRL, SRA, ROL, ROR)
//   - op_is_reserved  : true for the reserved op codes 101..111
//   - slice_levels    : how many mux levels a given register slice owns
//   - slice_lo        : index of the first mux level owned by a slice
//   Mux levels are shared out evenly across slices; any remainder goes to
//   the earliest slices, so slice 0 is never shorter than a later one.
// ---------------------------------------------------------------------------
package barrel_shift_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } bsp_op_e;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return (op > 3'd4);
  endfunction

  function automatic int slice_levels(input int levels, input int stages, input int idx);
    return (levels / stages) + ((idx < (levels % stages)) ? 1 : 0);
  endfunction

  function automatic int slice_lo(input int levels, input int stages, input int idx);
    int lo;
    lo = 0;
    for (int k = 0; k < idx; k++) begin
      lo += slice_levels(levels, stages, k);
    end
    return lo;
  endfunction

endpackage

// File: rtl/bsp_slice.sv
// ---------------------------------------------------------------------------
// bsp_slice
//   One register slice of the barrel shifter. Applies mux levels LO..HI-1
//   (level i shifts/rotates by 2^i when in_amt[i] is set) to the incoming
//   beat and registers the result together with amt, op and a valid bit.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   upstream handshake (in_ready = slice can load)
//     in_data/amt/op      beat from the previous slice (or the block input)
//     out_valid/out_ready downstream handshake (out_ready = next slice loads)
//     out_data/amt/op     registered beat
//     out_zero            registered (result == 0); constant 0 unless ZFLAG
// ---------------------------------------------------------------------------
module bsp_slice
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO    = 0,
  parameter int HI    = 1,
  parameter bit ZFLAG = 1'b0,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [2:0]       out_op,
  output logic             out_zero
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   amt_q,   amt_d;
  logic [2:0]       op_q,    op_d;
  logic             zero_q,  zero_d;
  logic [WIDTH-1:0] shifted;
  logic             load;

  // Empty, or the current occupant leaves this cycle.
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  // Each level moves by a power of two, so chaining levels composes the
  // full amount. SRA keeps the original sign because every step preserves
  // the MSB. Reserved ops skip all levels and pass the data through.
  always_comb begin
    shifted = in_data;
    if (!op_is_reserved(in_op)) begin
      for (int lvl = LO; lvl < HI; lvl++) begin
        if (in_amt[lvl]) begin
          case (bsp_op_e'(in_op))
            OP_SLL:  shifted = shifted << (1 << lvl);
            OP_SRL:  shifted = shifted >> (1 << lvl);
            OP_SRA:  shifted = $signed(shifted) >>> (1 << lvl);
            OP_ROL:  shifted = (shifted << (1 << lvl)) | (shifted >> (WIDTH - (1 << lvl)));
            OP_ROR:  shifted = (shifted >> (1 << lvl)) | (shifted << (WIDTH - (1 << lvl)));
            default: shifted = shifted;
          endcase
        end
      end
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    zero_d  = zero_q;
    if (in_ready) begin
      // A slice whose occupant leaves with nothing behind it becomes a bubble.
      valid_d = in_valid;
    end
    if (load) begin
      data_d = shifted;
      amt_d  = in_amt;
      op_d   = in_op;
      zero_d = ZFLAG ? (shifted == '0) : 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  // NOTE: the payload registers are reset too (not just valid), because the
  // result port must read 0 while the block is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_op    = op_q;
  assign out_zero  = zero_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shift_pipe
//   Pipelined WIDTH-bit barrel shifter/rotator (SLL, SRL, SRA, ROL, ROR)
//   built from STAGES bsp_slice register slices with valid/ready on both
//   sides. Latency STAGES, one beat per cycle, capacity STAGES beats.
//   Parameters: WIDTH (power of two, 8..128), STAGES (1..$clog2(WIDTH)).
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid/in_ready          input handshake
//     in_data/in_amt/in_op       operand, shift amount, operation
//     out_valid/out_ready        output handshake
//     out_data                   result
//     out_err                    result beat came from a reserved op
//     out_zero                   result == 0 (only with the macro below)
//   Build option: define BARREL_SHIFT_PIPE_ZFLAG_EN to add out_zero.
// ---------------------------------------------------------------------------
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
  ,
  output logic             out_zero
`endif
);

`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
  localparam bit ZFLAG_EN = 1'b1;
`else
  localparam bit ZFLAG_EN = 1'b0;
`endif

  // Chain index i is the input side of slice i; index STAGES is the output.
  logic [STAGES:0]  vld_w;
  logic [STAGES:0]  rdy_w;
  logic [WIDTH-1:0] data_w [STAGES+1];
  logic [SHW-1:0]   amt_w  [STAGES+1];
  logic [2:0]       op_w   [STAGES+1];
  logic [STAGES-1:0] zero_w;

  // Holds in_ready low until the first edge after reset release.
  logic init_done_q, init_done_d;

  always_comb begin
    init_done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
    end
  end

  assign vld_w[0]      = in_valid && init_done_q;
  assign data_w[0]     = in_data;
  assign amt_w[0]      = in_amt;
  assign op_w[0]       = in_op;
  assign rdy_w[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    localparam int LO = slice_lo(SHW, STAGES, i);
    localparam int HI = LO + slice_levels(SHW, STAGES, i);

    bsp_slice #(
      .WIDTH (WIDTH),
      .LO    (LO),
      .HI    (HI),
      .ZFLAG (ZFLAG_EN && (i == STAGES - 1))
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_w[i]),
      .in_ready  (rdy_w[i]),
      .in_data   (data_w[i]),
      .in_amt    (amt_w[i]),
      .in_op     (op_w[i]),
      .out_valid (vld_w[i+1]),
      .out_ready (rdy_w[i+1]),
      .out_data  (data_w[i+1]),
      .out_amt   (amt_w[i+1]),
      .out_op    (op_w[i+1]),
      .out_zero  (zero_w[i])
    );
  end

  // in_ready is combinational from out_ready through every slice's valid.
  assign in_ready  = init_done_q && rdy_w[0];
  assign out_valid = vld_w[STAGES];
  assign out_data  = data_w[STAGES];
  assign out_err   = vld_w[STAGES] && op_is_reserved(op_w[STAGES]);

`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
  assign out_zero = zero_w[STAGES-1];
`endif

  // The fully-consumed amount and the per-slice zero flags of earlier
  // slices have no consumer.
  logic unused_sink;
  assign unused_sink = ^{amt_w[STAGES], zero_w};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_shift_pipe
//   Two instances: dut_a (WIDTH=32, STAGES=2) and dut_b (WIDTH=64, STAGES=1).
//   A bit-index reference model predicts each accepted beat; a scoreboard
//   compares every valid output cycle (including stalled ones) in order.
//   Define BARREL_SHIFT_PIPE_ZFLAG_EN to also check out_zero.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut_a: 32-bit, 2 stages
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [31:0] a_in_data, a_out_data;
  logic [4:0]  a_in_amt;
  logic [2:0]  a_in_op;
  // dut_b: 64-bit, 1 stage
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [63:0] b_in_data, b_out_data;
  logic [5:0]  b_in_amt;
  logic [2:0]  b_in_op;
`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
  logic a_out_zero, b_out_zero;
`endif

  barrel_shift_pipe #(.WIDTH(32), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_amt(a_in_amt), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_err(a_out_err)
`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
    , .out_zero(a_out_zero)
`endif
  );

  barrel_shift_pipe #(.WIDTH(64), .STAGES(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_amt(b_in_amt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_err(b_out_err)
`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
    , .out_zero(b_out_zero)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int acc_a    = 0;
  int acc_b    = 0;

  typedef struct {
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: result bit j is taken from a source bit index computed from
  // the op; out-of-range sources become the fill bit.
  function automatic logic [127:0] ref_shift(input logic [127:0] d, input int w,
                                             input int amt, input int op);
    logic [127:0] r;
    int src;
    r = '0;
    if (op > 4) return d;
    for (int j = 0; j < w; j++) begin
      case (op)
        0:       src = j - amt;
        1, 2:    src = j + amt;
        3:       src = (j - amt + w) % w;
        default: src = (j + amt) % w;
      endcase
      if (src >= 0 && src < w) r[j] = d[src];
      else if (op == 2)        r[j] = d[w-1];
      else                     r[j] = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard/compare process: outputs and handshakes sampled mid-cycle.
  always @(negedge clk) begin
    if (a_out_valid) begin
      if (q_a.size() == 0) flag_fail("a_unexpected_beat");
      else begin
        check("a_data", {96'b0, a_out_data}, q_a[0].data);
        check("a_err", {127'b0, a_out_err}, {127'b0, q_a[0].err});
`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
        check("a_zero", {127'b0, a_out_zero}, {127'b0, (q_a[0].data == '0)});
`endif
        if (a_out_ready) void'(q_a.pop_front());
      end
    end
    if (a_in_valid && a_in_ready) begin
      q_a.push_back('{data: ref_shift({96'b0, a_in_data}, 32, int'(a_in_amt), int'(a_in_op)),
                      err:  (a_in_op > 3'd4)});
      acc_a++;
    end
    if (b_out_valid) begin
      if (q_b.size() == 0) flag_fail("b_unexpected_beat");
      else begin
        check("b_data", {64'b0, b_out_data}, q_b[0].data);
        check("b_err", {127'b0, b_out_err}, {127'b0, q_b[0].err});
`ifdef BARREL_SHIFT_PIPE_ZFLAG_EN
        check("b_zero", {127'b0, b_out_zero}, {127'b0, (q_b[0].data == '0)});
`endif
        if (b_out_ready) void'(q_b.pop_front());
      end
    end
    if (b_in_valid && b_in_ready) begin
      q_b.push_back('{data: ref_shift({64'b0, b_in_data}, 64, int'(b_in_amt), int'(b_in_op)),
                      err:  (b_in_op > 3'd4)});
      acc_b++;
    end
  end

  // Presents a beat and returns one cycle after it is accepted, leaving
  // in_valid high so a following call streams back-to-back.
  task automatic send_a(input logic [31:0] d, input logic [4:0] amt, input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    a_in_valid = 1'b1; a_in_data = d; a_in_amt = amt; a_in_op = op;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) flag_fail("a_send_timeout");
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] pick_amt(input int w);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 6'd0;
    if (r == 1) return 6'(w - 1);
    return 6'($urandom_range(0, w - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp [6];
    int acc0;
    bit took;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_op = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_op = '0; b_out_ready = 1'b1;

    // Model pins (hand-computed)
    check("pin_sll", ref_shift(128'h8000_0001, 32, 1, 0), 128'h0000_0002);
    check("pin_srl", ref_shift(128'h8000_0000, 32, 4, 1), 128'h0800_0000);
    check("pin_sra", ref_shift(128'h8000_0000, 32, 4, 2), 128'hF800_0000);
    check("pin_ror", ref_shift(128'h0000_00F1, 32, 4, 4), 128'h1000_000F);
    check("pin_rol", ref_shift(128'h8000_0001, 32, 31, 3), 128'hC000_0000);
    check("pin_rsv", ref_shift(128'hDEAD_BEEF, 32, 5, 7), 128'hDEAD_BEEF);
    check("pin_rol64", ref_shift(128'h8000_0000_0000_0001, 64, 63, 3), 128'hC000_0000_0000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid", {127'b0, a_out_valid}, 128'd0);
    check("rst_a_in_ready", {127'b0, a_in_ready}, 128'd0);
    check("rst_a_out_data", {96'b0, a_out_data}, 128'd0);
    check("rst_a_out_err", {127'b0, a_out_err}, 128'd0);
    check("rst_b_out_valid", {127'b0, b_out_valid}, 128'd0);
    #1 rst_n = 1'b1;
    #1 check("rel_in_ready_before_edge", {127'b0, a_in_ready}, 128'd0);
    @(posedge clk); #1;
    check("rel_in_ready_after_edge", {127'b0, a_in_ready}, 128'd1);

    // Latency: accept cycle 0, result visible in cycle 2
    send_a(32'h8000_0001, 5'd1, 3'd0);
    a_in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", {127'b0, a_out_valid}, 128'd0);
    @(negedge clk);
    check("lat_c2_valid", {127'b0, a_out_valid}, 128'd1);
    check("lat_c2_data", {96'b0, a_out_data}, 128'h2);

    // Directed vectors, streamed back-to-back
    send_a(32'h8000_0000, 5'd4, 3'd1);
    send_a(32'h8000_0000, 5'd4, 3'd2);
    send_a(32'h0000_00F1, 5'd4, 3'd4);
    send_a(32'h8000_0001, 5'd31, 3'd3);
    for (int op = 0; op < 5; op++) send_a(32'hDEAD_BEEF, 5'd0, 3'(op));
    send_a(32'hDEAD_BEEF, 5'd9, 3'd7);
    send_a(32'h1234_5678, 5'd3, 3'd0);
    send_a(32'h0000_0001, 5'd1, 3'd1);
    a_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Backpressure: 6 beats, out_ready low for 5 cycles
    for (int k = 0; k < 6; k++) bp[k] = $urandom;
    acc0 = acc_a;
    a_out_ready = 1'b0;
    send_a(bp[0], 5'd7, 3'd3);
    send_a(bp[1], 5'd13, 3'd2);
    a_in_valid = 1'b1; a_in_data = bp[2]; a_in_amt = 5'd1; a_in_op = 3'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", {127'b0, a_in_ready}, 128'd0);
    end
    check("bp_accepted_two", 128'(acc_a - acc0), 128'd2);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    #1 check("bp_full_in_ready", {127'b0, a_in_ready}, 128'd1);
    send_a(bp[2], 5'd1, 3'd4);
    send_a(bp[3], 5'd31, 3'd0);
    send_a(bp[4], 5'd16, 3'd1);
    send_a(bp[5], 5'd0, 3'd6);
    a_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_accepted_six", 128'(acc_a - acc0), 128'd6);
    check("bp_drained", 128'(q_a.size()), 128'd0);

    // Reset with two beats in flight
    send_a(32'hAAAA_5555, 5'd3, 3'd0);
    send_a(32'h5555_AAAA, 5'd5, 3'd4);
    a_in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {127'b0, a_out_valid}, 128'd0);
    check("mid_rst_in_ready", {127'b0, a_in_ready}, 128'd0);
    check("mid_rst_out_data", {96'b0, a_out_data}, 128'd0);
    check("mid_rst_out_err", {127'b0, a_out_err}, 128'd0);
    q_a.delete();
    q_b.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("mid_rel_in_ready_before_edge", {127'b0, a_in_ready}, 128'd0);
    @(posedge clk); #1;
    check("mid_rel_in_ready_after_edge", {127'b0, a_in_ready}, 128'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_beat", {127'b0, a_out_valid}, 128'd0);
    end
    @(posedge clk); #1;

    // Random sweep, dut_a
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      took = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (took || !a_in_valid) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_in_data  = $urandom;
        a_in_amt   = 5'(pick_amt(32));
        a_in_op    = 3'($urandom_range(0, 7));
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("a_rand_drained", 128'(q_a.size()), 128'd0);

    // Random sweep, dut_b
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      took = b_in_valid && b_in_ready;
      @(posedge clk); #1;
      if (took || !b_in_valid) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_in_data  = {$urandom, $urandom};
        if ($urandom_range(0, 15) == 0) b_in_data = 64'd1;
        b_in_amt   = pick_amt(64);
        b_in_op    = 3'($urandom_range(0, 7));
      end
      b_out_ready = ($urandom_range(0, 3) != 0);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("b_rand_drained", 128'(q_b.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
